// File: rtl/vscpu_mem_pkg.sv
// Shared constants for the VSCPU memory responder: I/O offsets, STATUS layout
// and the default I/O window base.
package vscpu_mem_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_CYCLES = 4'd2;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    localparam logic [13:0] DEFAULT_IO_BASE = 14'h3FF0;

    // STATUS only has a 4-bit count field.
    function automatic logic [3:0] sat_cnt(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/vscpu_tx_fifo.sv
// Character-output FIFO: flop storage, power-of-two depth, head shown
// combinationally from storage so the consumer sees it while non-empty.
module vscpu_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO only succeeds when the head leaves that cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/vscpu_mem_responder.sv
// VSCPU bus responder: RAM below IO_BASE, 16-word I/O window above it.
// Define VSCPU_RESP_CYCLE_CNT_EN to build the free-running cycle counter.
module vscpu_mem_responder
    import vscpu_mem_pkg::*;
#(
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(DEFAULT_IO_BASE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int RAM_WORDS = int'(IO_BASE);
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] mem [RAM_WORDS];

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              io_sel;
    logic [3:0]        off;
    logic              push, pop;
    logic              full, empty;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] status;

`ifdef VSCPU_RESP_CYCLE_CNT_EN
    logic [DATA_W-1:0] cycle_q, cycle_d;
`endif

    assign io_sel   = (addr >= IO_BASE);
    assign off      = addr[3:0];
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = !empty;
    assign dout     = dout_q;

    vscpu_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din[7:0]),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (tx_data)
    );

    always_comb begin
        status                     = '0;
        status[ST_EMPTY]           = empty;
        status[ST_FULL]            = full;
        status[ST_OVF]             = ovf_q;
        status[ST_CNT_LSB +: 4]    = sat_cnt(32'(count));
    end

    // I/O reads return pre-update values; writes take effect at the same edge.
    always_comb begin
        dout_d = '0;
        push   = 1'b0;
        ovf_d  = ovf_q;
`ifdef VSCPU_RESP_CYCLE_CNT_EN
        cycle_d = cycle_q + DATA_W'(1);
`endif
        if (!io_sel) begin
            dout_d = mem[addr];
        end else begin
            unique case (off)
                OFF_TXDATA: begin
                    push = we;
                end
                OFF_STATUS: begin
                    dout_d = status;
                    if (we) ovf_d = 1'b0;
                end
`ifdef VSCPU_RESP_CYCLE_CNT_EN
                OFF_CYCLES: begin
                    dout_d = cycle_q;
                    if (we) cycle_d = din;
                end
`endif
                default: ;
            endcase
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !io_sel) begin
            mem[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef VSCPU_RESP_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
`endif

endmodule
